// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters.
// Each grant runs the counter from 0 to the winner's captured length, then pulses done.
module cnt_sched #(
   parameter int NREQ = 4,
   parameter int CW   = 8
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] len,
   input  logic               abort,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic               busy,
   output logic [CW-1:0]      cnt_val
);

   localparam int unsigned NR = NREQ;
   localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   len_q, len_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [IW-1:0]   win_q, win_d;

   logic            hit_hi, hit_any;
   logic [IW-1:0]   sel_hi, sel_any, arb_win, win_inc;
   logic [CW-1:0]   arb_len;
   logic [NREQ-1:0] arb_onehot;
   logic            term, cancel;

   // First requester at or above rr_q wins; otherwise the lowest requester (wrap).
   always_comb begin
      hit_hi     = 1'b0;
      hit_any    = 1'b0;
      sel_hi     = '0;
      sel_any    = '0;
      arb_len    = '0;
      arb_onehot = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (req[i] && !hit_hi && (IW'(i) >= rr_q)) begin
            hit_hi = 1'b1;
            sel_hi = IW'(i);
         end
         if (req[i] && !hit_any) begin
            hit_any = 1'b1;
            sel_any = IW'(i);
         end
      end
      arb_win = hit_hi ? sel_hi : sel_any;
      for (int unsigned i = 0; i < NR; i++) begin
         if (IW'(i) == arb_win) begin
            arb_len       = len[i*CW +: CW];
            arb_onehot[i] = 1'b1;
         end
      end
   end

   // gnt_q is the winner's one-hot during RUN, so it doubles as the req monitor mask.
   always_comb begin
      win_inc = (win_q == IW'(NR - 1)) ? '0 : win_q + IW'(1);
      term    = (cnt_q == len_q);
      cancel  = abort || !(|(req & gnt_q));
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      cnt_d   = cnt_q;
      len_d   = len_q;
      rr_d    = rr_q;
      win_d   = win_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            gnt_d = '0;
            if (|req) begin
               state_d = RUN;
               gnt_d   = arb_onehot;
               len_d   = arb_len;
               win_d   = arb_win;
            end
         end
         RUN: begin
            if (cancel) begin
               state_d = IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
               rr_d    = win_inc;
            end else if (term) begin
               state_d = DONE;
               gnt_d   = '0;
               done_d  = gnt_q;
               rr_d    = win_inc;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         rr_q    <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign busy    = (state_q != IDLE);
   assign cnt_val = cnt_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Self-checking bench for cnt_sched: directed scenarios plus randomized traffic
// compared against a service-level model of the scheduler.
module tb_cnt_sched;

   localparam int NREQ = 4;
   localparam int CW   = 8;
   localparam int VW   = 2*NREQ + CW + 1;

   logic               clk = 1'b0;
   logic               rst_b;
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len;
   logic               abort;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic               busy;
   logic [CW-1:0]      cnt_val;
   logic [VW-1:0]      obs;

   int checks   = 0;
   int failures = 0;

   // Model: owner of the counter (-1 none), requester in its done cycle (-1 none).
   int m_owner, m_done, m_cnt, m_len, m_ptr;

   cnt_sched #(.NREQ(NREQ), .CW(CW)) dut (
      .clk     (clk),
      .rst_b   (rst_b),
      .req     (req),
      .len     (len),
      .abort   (abort),
      .gnt     (gnt),
      .done    (done),
      .busy    (busy),
      .cnt_val (cnt_val)
   );

   always #5 clk = ~clk;
   assign obs = {gnt, done, busy, cnt_val};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_owner = -1;
      m_done  = -1;
      m_cnt   = 0;
      m_len   = 0;
      m_ptr   = 0;
   endtask

   // Applies one clock edge of scheduler rules using the currently driven inputs.
   task automatic model_edge();
      if (m_owner >= 0) begin
         if (abort || !req[m_owner]) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_cnt   = 0;
         end else if (m_cnt == m_len) begin
            m_done  = m_owner;
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
         end else begin
            m_cnt++;
         end
      end else if (m_done >= 0) begin
         m_done = -1;
         m_cnt  = 0;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            int j = (m_ptr + k) % NREQ;
            if (req[j] && m_owner < 0) begin
               m_owner = j;
               m_len   = len[j*CW +: CW];
               m_cnt   = 0;
            end
         end
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [NREQ-1:0] g, d;
      logic            b;
      g = '0;
      d = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      if (m_done >= 0)  d[m_done]  = 1'b1;
      b = (m_owner >= 0) || (m_done >= 0);
      return {g, d, b, CW'(m_cnt)};
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      req   = '0;
      abort = 1'b0;
      len   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      req   = '1;
      len   = '1;
      abort = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL reset_async: got %h expected %h", obs, {VW{1'b0}});
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL reset_held: got %h expected %h", obs, {VW{1'b0}});
      end
      rst_b = 1'b1;
   endtask

   task automatic test_single();
      logic [VW-1:0] want;
      do_reset();
      len[0 +: CW] = 8'd5;
      req = 4'b0001;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k <= 6)      want = {4'b0001, 4'b0000, 1'b1, CW'(k - 1)};
         else if (k == 7) want = {4'b0000, 4'b0001, 1'b1, CW'(5)};
         else             want = '0;
         checks++;
         if (obs !== want) begin
            failures++;
            $display("FAIL single_cyc%0d: got %h expected %h", k, obs, want);
         end
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL single_model_cyc%0d: got %h expected %h", k, obs, exp_vec());
         end
         if (k == 7) req = '0;
      end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] exp_order [5];
      logic [NREQ-1:0] order [$];
      int              widths [$];
      int              dtimes [$];
      logic [NREQ-1:0] prev, got;
      int              run, gw, dt;
      exp_order[0] = 4'b0001;
      exp_order[1] = 4'b0010;
      exp_order[2] = 4'b0100;
      exp_order[3] = 4'b1000;
      exp_order[4] = 4'b0001;
      do_reset();
      for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = 8'd2;
      req  = '1;
      prev = '0;
      run  = 0;
      for (int c = 1; c <= 28; c++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL rr_model_cyc%0d: got %h expected %h", c, obs, exp_vec());
         end
         if (gnt != '0 && gnt != prev) order.push_back(gnt);
         if (gnt != '0) run++;
         else if (run > 0) begin
            widths.push_back(run);
            run = 0;
         end
         if (done != '0) dtimes.push_back(c);
         prev = gnt;
      end
      req = '0;
      for (int k = 0; k < 5; k++) begin
         got = (k < order.size()) ? order[k] : 'x;
         checks++;
         if (got !== exp_order[k]) begin
            failures++;
            $display("FAIL rr_order%0d: got %b expected %b", k, got, exp_order[k]);
         end
         gw = (k < widths.size()) ? widths[k] : -1;
         checks++;
         if (gw != 3) begin
            failures++;
            $display("FAIL rr_width%0d: got %0d expected 3", k, gw);
         end
      end
      for (int k = 0; k < 4; k++) begin
         dt = (k + 1 < dtimes.size()) ? dtimes[k+1] - dtimes[k] : -1;
         checks++;
         if (dt != 5) begin
            failures++;
            $display("FAIL rr_done_gap%0d: got %0d expected 5", k, dt);
         end
      end
   endtask

   task automatic test_len_zero();
      logic [VW-1:0] want [3];
      want[0] = {4'b0010, 4'b0000, 1'b1, CW'(0)};
      want[1] = {4'b0000, 4'b0010, 1'b1, CW'(0)};
      want[2] = '0;
      do_reset();
      len[CW +: CW] = 8'd0;
      req = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (obs !== want[k]) begin
            failures++;
            $display("FAIL len0_cyc%0d: got %h expected %h", k, obs, want[k]);
         end
         if (k == 1) req = '0;
      end
   endtask

   task automatic test_len_max();
      int gcycles, dcount, maxcnt, c;
      do_reset();
      len[2*CW +: CW] = 8'd255;
      req     = 4'b0100;
      gcycles = 0;
      dcount  = 0;
      maxcnt  = 0;
      c       = 0;
      while (dcount == 0 && c < 300) begin
         step();
         c++;
         if (gnt === 4'b0100) gcycles++;
         if (done !== '0) dcount++;
         if (int'(cnt_val) > maxcnt) maxcnt = int'(cnt_val);
         if (obs !== exp_vec()) begin
            checks++;
            failures++;
            $display("FAIL lenmax_model_cyc%0d: got %h expected %h", c, obs, exp_vec());
         end
      end
      req = '0;
      checks++;
      if (gcycles != 256) begin
         failures++;
         $display("FAIL lenmax_gnt_cycles: got %0d expected 256", gcycles);
      end
      checks++;
      if (maxcnt != 255) begin
         failures++;
         $display("FAIL lenmax_peak_cnt: got %0d expected 255", maxcnt);
      end
      checks++;
      if (dcount != 1) begin
         failures++;
         $display("FAIL lenmax_done_count: got %0d expected 1", dcount);
      end
   endtask

   // v=0 drops the winner's req at cnt=4, v=1 aborts at cnt=4 with req still held.
   task automatic test_cancel();
      logic [VW-1:0] want;
      for (int v = 0; v < 2; v++) begin
         do_reset();
         len[0 +: CW]  = 8'd10;
         len[CW +: CW] = 8'd3;
         req = 4'b0011;
         for (int k = 0; k < 5; k++) step();
         checks++;
         want = {4'b0001, 4'b0000, 1'b1, CW'(4)};
         if (obs !== want) begin
            failures++;
            $display("FAIL cancel%0d_precnt: got %h expected %h", v, obs, want);
         end
         if (v == 0) req = 4'b0010;
         else        abort = 1'b1;
         step();
         abort = 1'b0;
         checks++;
         if (obs !== '0) begin
            failures++;
            $display("FAIL cancel%0d_drop: got %h expected %h", v, obs, {VW{1'b0}});
         end
         step();
         want = {4'b0010, 4'b0000, 1'b1, CW'(0)};
         checks++;
         if (obs !== want) begin
            failures++;
            $display("FAIL cancel%0d_next: got %h expected %h", v, obs, want);
         end
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL cancel%0d_model: got %h expected %h", v, obs, exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      logic [VW-1:0] want;
      do_reset();
      len[0 +: CW] = 8'd10;
      req = 4'b0001;
      for (int k = 0; k < 4; k++) step();
      checks++;
      if (cnt_val !== CW'(3)) begin
         failures++;
         $display("FAIL arst_precnt: got %0d expected 3", cnt_val);
      end
      #2;
      rst_b = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL arst_midservice: got %h expected %h", obs, {VW{1'b0}});
      end
      req = 4'b0011;
      len[CW +: CW] = 8'd1;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL arst_held: got %h expected %h", obs, {VW{1'b0}});
      end
      rst_b = 1'b1;
      step();
      want = {4'b0001, 4'b0000, 1'b1, CW'(0)};
      checks++;
      if (obs !== want) begin
         failures++;
         $display("FAIL arst_priority: got %h expected %h", obs, want);
      end
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 15) == 0) begin
               req[i] = ~req[i];
               if (req[i]) len[i*CW +: CW] = CW'($urandom_range(0, 20));
            end
         end
         if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, NREQ - 1);
            len[r*CW +: CW] = CW'($urandom_range(0, 20));
         end
         abort = ($urandom_range(0, 39) == 0);
         step();
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL random_cyc%0d: got %h expected %h", c, obs, exp_vec());
         end
      end
      abort = 1'b0;
      req   = '0;
   endtask

   initial begin
      rst_b = 1'b0;
      req   = '0;
      len   = '0;
      abort = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_len_zero();
      test_len_max();
      test_cancel();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
